lc3_mem_ctrl: RTL and testbench

//  Parametrised LC-3 memory/I-O unit, successor to the fixed single-cycle memory block. Holds MAR/MDR,

---
 rtl/lc3_mem_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_ctrl.sv
// rtl/lc3_mem_ctrl.sv - LC-3 memory/I-O unit: MAR/MDR, wait-state access FSM, keyboard/display registers
module lc3_mem_ctrl #(
    parameter int                DATA_W      = 16,
    parameter int                MEM_AW      = 12,
    parameter int                WAIT_STATES = 2,
    parameter logic [DATA_W-1:0] KBSR_ADDR   = 16'hFE00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              LDMAR,
    input  logic              LDMDR,
    input  logic              MIOEN,
    input  logic              RW,
    input  logic              GateMDR,
    output logic [DATA_W-1:0] mdr_out,
    output logic              R,
    input  logic              kb_valid,
    input  logic [7:0]        kb_data,
    output logic              kb_ready,
    output logic              ddr_valid,
    output logic [7:0]        ddr_data,
    input  logic              ddr_ready,
    output logic              INT
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [DATA_W-1:0] KBDR_ADDR = KBSR_ADDR + DATA_W'(2);
    localparam logic [DATA_W-1:0] DSR_ADDR  = KBSR_ADDR + DATA_W'(4);
    localparam logic [DATA_W-1:0] DDR_ADDR  = KBSR_ADDR + DATA_W'(6);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;

    logic [DATA_W-1:0]  mar;
    logic [DATA_W-1:0]  mdr;
    logic [DATA_W-1:0]  mem [0:(2**MEM_AW)-1];
    logic [DATA_W-1:0]  rd_data;

    logic               kb_rdy;
    logic               kb_ie;
    logic [7:0]         kbdr;
    logic               dsr_rdy;
    logic               dsr_ie;
    logic [DATA_W-1:0]  ddr;

    logic               is_kbsr, is_kbdr, is_dsr, is_ddr, is_dev;
    logic               acc_done, wr_en, rd_en;

    assign is_kbsr  = (mar == KBSR_ADDR);
    assign is_kbdr  = (mar == KBDR_ADDR);
    assign is_dsr   = (mar == DSR_ADDR);
    assign is_ddr   = (mar == DDR_ADDR);
    assign is_dev   = is_kbsr | is_kbdr | is_dsr | is_ddr;

    assign acc_done = (state == S_DONE);
    assign wr_en    = acc_done & RW;
    assign rd_en    = acc_done & ~RW;

    assign mdr_out   = GateMDR ? mdr : {DATA_W{1'bz}};
    assign kb_ready  = ~kb_rdy;
    assign ddr_data  = ddr[7:0];
    assign INT       = (kb_rdy & kb_ie) | (dsr_rdy & dsr_ie);

    // Next-state: the counter holds the BUSY cycles still owed; zero wait states skip BUSY entirely
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (MIOEN) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_BUSY;
                        cnt_nxt   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            S_BUSY: begin
                if (!MIOEN) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; R is registered so it is high exactly during the DONE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            R     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            R     <= (state_nxt == S_DONE);
        end
    end

    // Read mux: device registers shadow the array, array ignores upper MAR bits
    always_comb begin
        rd_data = mem[mar[MEM_AW-1:0]];
        if (is_kbsr) begin
            rd_data = {kb_rdy, kb_ie, {(DATA_W-2){1'b0}}};
        end else if (is_kbdr) begin
            rd_data = {{(DATA_W-8){1'b0}}, kbdr};
        end else if (is_dsr) begin
            rd_data = {dsr_rdy, dsr_ie, {(DATA_W-2){1'b0}}};
        end else if (is_ddr) begin
            rd_data = ddr;
        end
    end

    // Memory array write, committed only at the end of the DONE cycle
    always_ff @(posedge clk) begin
        if (wr_en && !is_dev) begin
            mem[mar[MEM_AW-1:0]] <= mdr;
        end
    end

    // MAR/MDR: MDR takes the bus when no access is active, read data when the access completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mar <= '0;
            mdr <= '0;
        end else begin
            if (LDMAR) begin
                mar <= bus_in;
            end
            if (LDMDR && !MIOEN) begin
                mdr <= bus_in;
            end else if (LDMDR && MIOEN && !RW && R) begin
                mdr <= rd_data;
            end
        end
    end

    // Keyboard: a new char is accepted only once the previous one has been read out of KBDR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb_rdy <= 1'b0;
            kb_ie  <= 1'b0;
            kbdr   <= '0;
        end else begin
            if (wr_en && is_kbsr) begin
                kb_ie <= mdr[DATA_W-2];
            end
            if (rd_en && is_kbdr) begin
                kb_rdy <= 1'b0;
            end
            if (kb_valid && kb_ready) begin
                kbdr   <= kb_data;
                kb_rdy <= 1'b1;
            end
        end
    end

    // Display: a DDR write is taken only when the previous char has been consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsr_rdy   <= 1'b1;
            dsr_ie    <= 1'b0;
            ddr       <= '0;
            ddr_valid <= 1'b0;
        end else begin
            if (wr_en && is_dsr) begin
                dsr_ie <= mdr[DATA_W-2];
            end
            if (wr_en && is_ddr && dsr_rdy) begin
                ddr       <= mdr;
                dsr_rdy   <= 1'b0;
                ddr_valid <= 1'b1;
            end else if (ddr_valid && ddr_ready) begin
                ddr_valid <= 1'b0;
                dsr_rdy   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb/tb_lc3_mem_ctrl.sv - scoreboard bench for lc3_mem_ctrl
`timescale 1ns/1ps
module tb_lc3_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus_in;
    logic        LDMAR, LDMDR, MIOEN, RW, GateMDR;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        ddr_ready;
    wire  [15:0] mdr_out;
    logic        R, kb_ready, ddr_valid, INT;
    logic [7:0]  ddr_data;

    logic        mioen0;
    wire  [15:0] mdr_out0;
    logic        r0, kb_ready0, ddr_valid0, int0;
    logic [7:0]  ddr_data0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];

    lc3_mem_ctrl #(.WAIT_STATES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .LDMAR(LDMAR), .LDMDR(LDMDR),
        .MIOEN(MIOEN), .RW(RW), .GateMDR(GateMDR), .mdr_out(mdr_out), .R(R),
        .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
        .ddr_valid(ddr_valid), .ddr_data(ddr_data), .ddr_ready(ddr_ready), .INT(INT)
    );

    lc3_mem_ctrl #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .LDMAR(LDMAR), .LDMDR(LDMDR),
        .MIOEN(mioen0), .RW(RW), .GateMDR(GateMDR), .mdr_out(mdr_out0), .R(r0),
        .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready0),
        .ddr_valid(ddr_valid0), .ddr_data(ddr_data0), .ddr_ready(ddr_ready), .INT(int0)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full access: load MAR (and MDR for writes), then hold MIOEN until R
    task automatic access(input logic [15:0] addr, input logic [15:0] wdata,
                          input logic rw, input bit kb_in_done);
        int n;
        bit seen;
        logic [15:0] exp;
        bus_in = addr; LDMAR = 1'b1; step(); LDMAR = 1'b0;
        if (rw) begin
            bus_in = wdata; LDMDR = 1'b1; step(); LDMDR = 1'b0;
        end
        RW = rw; MIOEN = 1'b1; LDMDR = !rw;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            step(); n++;
            if (R) seen = 1'b1;
        end
        check_eq("r_latency", n, 3);
        if (seen) begin
            if (kb_in_done) begin kb_valid = 1'b1; kb_data = 8'h43; end
            step();
            kb_valid = 1'b0;
        end
        MIOEN = 1'b0; LDMDR = 1'b0; RW = 1'b0;
        check_eq("r_width", R, 0);
        if (!rw) begin
            exp = exp_q.pop_front();
            check_eq("rd_data", mdr_out, exp);
        end
    endtask

    task automatic rd(input logic [15:0] addr, input logic [15:0] exp);
        exp_q.push_back(exp);
        access(addr, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        access(addr, data, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; bus_in = '0; LDMAR = 0; LDMDR = 0; MIOEN = 0; RW = 0; GateMDR = 1;
        kb_valid = 0; kb_data = '0; ddr_ready = 0; mioen0 = 0;
        step(); step();
        rst_n = 1'b1;
        step();
        check_eq("rst_r", R, 0);
        check_eq("rst_kb_ready", kb_ready, 1);
        check_eq("rst_ddr_valid", ddr_valid, 0);
        check_eq("rst_int", INT, 0);
        check_eq("rst_mdr", mdr_out, 16'h0000);
        check_eq("rst_r0", r0, 0);

        // reset in the middle of a write leaves memory untouched
        wr(16'h0030, 16'h5555);
        bus_in = 16'h1234; LDMDR = 1'b1; step(); LDMDR = 1'b0;
        RW = 1'b1; MIOEN = 1'b1;
        step(); step();
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_r_async", R, 0);
        step();
        rst_n = 1'b1; MIOEN = 1'b0; RW = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("rst_mid_r", R, 0);
            step();
        end
        check_eq("rst_mid_mdr", mdr_out, 16'h0000);
        rd(16'h0030, 16'h5555);
        rd(16'hFE04, 16'h8000);

        // basic write/read, aliasing, and MDR gating
        wr(16'h0010, 16'hBEEF);
        rd(16'h0010, 16'hBEEF);
        GateMDR = 1'b0; #1;
        check_eq("gate_off", (mdr_out !== 16'hBEEF), 1);
        GateMDR = 1'b1; #1;
        check_eq("gate_on", mdr_out, 16'hBEEF);
        rd(16'h1010, 16'hBEEF);

        // MIOEN dropped during BUSY aborts the write
        wr(16'h0020, 16'h1111);
        bus_in = 16'h0020; LDMAR = 1'b1; step(); LDMAR = 1'b0;
        bus_in = 16'h2222; LDMDR = 1'b1; step(); LDMDR = 1'b0;
        RW = 1'b1; MIOEN = 1'b1;
        step(); step();
        MIOEN = 1'b0; RW = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("abort_r", R, 0);
            step();
        end
        rd(16'h0020, 16'h1111);

        // keyboard
        wr(16'hFE00, 16'h4000);
        check_eq("kb_int_idle", INT, 0);
        kb_valid = 1'b1; kb_data = 8'h41; step(); kb_valid = 1'b0;
        check_eq("kb_ready_busy", kb_ready, 0);
        check_eq("kb_int", INT, 1);
        kb_valid = 1'b1; kb_data = 8'h42; step(); kb_valid = 1'b0;
        rd(16'hFE00, 16'hC000);
        check_eq("kb_int_held", INT, 1);
        exp_q.push_back(16'h0041);
        access(16'hFE02, 16'h0, 1'b0, 1'b1);
        check_eq("kb_ready_after_rd", kb_ready, 1);
        check_eq("kb_int_cleared", INT, 0);
        rd(16'hFE00, 16'h4000);
        wr(16'hFE00, 16'hBFFF);
        rd(16'hFE00, 16'h0000);

        // display
        wr(16'hFE04, 16'h4000);
        check_eq("dsr_int", INT, 1);
        wr(16'hFE04, 16'hBFFF);
        check_eq("dsr_int_off", INT, 0);
        rd(16'hFE04, 16'h8000);
        wr(16'hFE06, 16'h0058);
        check_eq("ddr_valid", ddr_valid, 1);
        check_eq("ddr_data", ddr_data, 8'h58);
        rd(16'hFE04, 16'h0000);
        wr(16'hFE06, 16'h0059);
        check_eq("ddr_data_kept", ddr_data, 8'h58);
        ddr_ready = 1'b1; step(); ddr_ready = 1'b0;
        check_eq("ddr_valid_clr", ddr_valid, 0);
        rd(16'hFE04, 16'h8000);
        rd(16'hFE06, 16'h0058);

        // zero wait states, back-to-back reads with MIOEN held
        bus_in = 16'h0010; LDMAR = 1'b1; step(); LDMAR = 1'b0;
        RW = 1'b0; mioen0 = 1'b1;
        step(); check_eq("ws0_r_c1", r0, 1);
        step(); check_eq("ws0_r_c2", r0, 0);
        step(); check_eq("ws0_r_c3", r0, 1);
        mioen0 = 1'b0;
        step(); step();
        check_eq("ws0_r_idle", r0, 0);

        check_eq("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
